// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared constants and decode helpers for the CHIP8 ALU issue slice
// Contents: register file geometry, 8XYN ALU opcodes, VF address,
// issue FSM state encoding and the legal-N decode helpers.
package chip8_pkg;
  localparam int NREGS = 16;
  localparam int DW    = 8;

  localparam logic [3:0] OP_ASSIGN = 4'h0;
  localparam logic [3:0] OP_OR     = 4'h1;
  localparam logic [3:0] OP_AND    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_ADD    = 4'h4;
  localparam logic [3:0] OP_SUB    = 4'h5;
  localparam logic [3:0] OP_SHR    = 4'h6;
  localparam logic [3:0] OP_SUBN   = 4'h7;
  localparam logic [3:0] OP_SHL    = 4'hE;

  localparam logic [3:0] REG_VF    = 4'hF;
  localparam logic [3:0] HI_ALU    = 4'h8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WB     = 2'd2;

  // Bit n set means 8XYn is an implemented ALU instruction (0-7 and E).
  localparam logic [15:0] LEGAL_N_MASK = 16'h40FF;

  function automatic logic n_legal(input logic [3:0] n);
    return LEGAL_N_MASK[n];
  endfunction

  // Shifts operate on Vy and write the result back to both Vx and Vy.
  function automatic logic n_writes_vy(input logic [3:0] n);
    return (n == OP_SHR) || (n == OP_SHL);
  endfunction

  // Arithmetic and shifts report a flag through VF; logic ops leave it alone.
  function automatic logic n_writes_vf(input logic [3:0] n);
    return (n == OP_ADD) || (n == OP_SUB) || (n == OP_SHR) ||
           (n == OP_SUBN) || (n == OP_SHL);
  endfunction
endpackage

// File: rtl/chip8_alu.sv
// rtl/chip8_alu.sv - CHIP8 8XYN ALU with one cycle of registered latency
// Ports: clk, rst (sync, active high); op1 (Vx), op2 (Vy), opcode (N) in;
// result, carry (carry / no-borrow / shifted-out bit), err (illegal N) out, all registered.
module chip8_alu
  import chip8_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] op1,
  input  logic [DW-1:0] op2,
  input  logic [3:0]    opcode,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          err
);
  logic [DW:0] sum;
  assign sum = {1'b0, op1} + {1'b0, op2};

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      carry  <= 1'b0;
      err    <= 1'b0;
    end else begin
      carry <= 1'b0;
      err   <= 1'b0;
      case (opcode)
        OP_ASSIGN: result <= op2;
        OP_OR:     result <= op1 | op2;
        OP_AND:    result <= op1 & op2;
        OP_XOR:    result <= op1 ^ op2;
        OP_ADD:    begin result <= sum[DW-1:0]; carry <= sum[DW]; end
        OP_SUB:    begin result <= op1 - op2; carry <= (op1 >= op2); end
        OP_SHR:    begin result <= op2 >> 1; carry <= op2[0]; end
        OP_SUBN:   begin result <= op2 - op1; carry <= (op2 >= op1); end
        OP_SHL:    begin result <= op2 << 1; carry <= op2[DW-1]; end
        default:   begin result <= '0; err <= 1'b1; end
      endcase
    end
  end
endmodule

// File: rtl/chip8_vreg_file.sv
// rtl/chip8_vreg_file.sv - V0-VF register file, three async reads, one three-lane write port
// Ports: clk, rst (sync, active high); ra_x/ra_y/ra_ext -> rd_x/rd_y/rd_ext (combinational);
// write lanes 0..2 (we*/wa*/wd*), a higher lane wins when addresses collide.
module chip8_vreg_file
  import chip8_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    ra_x,
  input  logic [3:0]    ra_y,
  input  logic [3:0]    ra_ext,
  output logic [DW-1:0] rd_x,
  output logic [DW-1:0] rd_y,
  output logic [DW-1:0] rd_ext,
  input  logic          we0,
  input  logic [3:0]    wa0,
  input  logic [DW-1:0] wd0,
  input  logic          we1,
  input  logic [3:0]    wa1,
  input  logic [DW-1:0] wd1,
  input  logic          we2,
  input  logic [3:0]    wa2,
  input  logic [DW-1:0] wd2
);
  logic [DW-1:0] regs [NREGS];

  assign rd_x   = regs[ra_x];
  assign rd_y   = regs[ra_y];
  assign rd_ext = regs[ra_ext];

  // Later non-blocking assignments override earlier ones, giving lane priority 2 > 1 > 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (we0) regs[wa0] <= wd0;
      if (we1) regs[wa1] <= wd1;
      if (we2) regs[wa2] <= wd2;
    end
  end
endmodule

// File: rtl/chip8_alu_issue.sv
// rtl/chip8_alu_issue.sv - owns V0-VF, issues 8XYN to the ALU and writes results back
// Ports: clk, rst (sync, active high); instr_valid/instr_ready/instr handshake;
// done/err one-cycle result pulses; alu_op1/alu_op2/alu_opcode to the ALU,
// alu_out/alu_carry/alu_err back; rd_addr/rd_data async read; wr_en/wr_addr/wr_data/wr_ready write.
module chip8_alu_issue
  import chip8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic        done,
  output logic        err,
  output logic [7:0]  alu_op1,
  output logic [7:0]  alu_op2,
  output logic [3:0]  alu_opcode,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry,
  input  logic        alu_err,
  input  logic [3:0]  rd_addr,
  output logic [7:0]  rd_data,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ready
);
  logic [1:0] state;
  logic [3:0] x_q, y_q, n_q, hi_q;
  logic [7:0] vx, vy;
  logic       in_wb, wb_ok;
  logic       we0, we1, we2;
  logic [3:0] wa0;
  logic [7:0] wd0;

  assign in_wb       = (state == ST_WB);
  assign instr_ready = (state == ST_IDLE);
  assign wr_ready    = !in_wb;

  assign alu_op1    = (state == ST_ISSUE) ? vx  : '0;
  assign alu_op2    = (state == ST_ISSUE) ? vy  : '0;
  assign alu_opcode = (state == ST_ISSUE) ? n_q : '0;

  assign wb_ok = in_wb && (hi_q == HI_ALU) && !alu_err && n_legal(n_q);

  // Lane 0 is shared: the Vx writeback owns it in WB, the external writer otherwise.
  always_comb begin
    we0 = wr_en;
    wa0 = wr_addr;
    wd0 = wr_data;
    if (in_wb) begin
      we0 = wb_ok;
      wa0 = x_q;
      wd0 = alu_out;
    end
  end

  assign we1 = wb_ok && n_writes_vy(n_q);
  assign we2 = wb_ok && n_writes_vf(n_q);

  chip8_vreg_file u_vregs (
    .clk    (clk),
    .rst    (rst),
    .ra_x   (x_q),
    .ra_y   (y_q),
    .ra_ext (rd_addr),
    .rd_x   (vx),
    .rd_y   (vy),
    .rd_ext (rd_data),
    .we0    (we0),
    .wa0    (wa0),
    .wd0    (wd0),
    .we1    (we1),
    .wa1    (y_q),
    .wd1    (alu_out),
    .we2    (we2),
    .wa2    (REG_VF),
    .wd2    ({7'b0, alu_carry})
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      done  <= 1'b0;
      err   <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      n_q   <= '0;
      hi_q  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            hi_q  <= instr[15:12];
            x_q   <= instr[11:8];
            y_q   <= instr[7:4];
            n_q   <= instr[3:0];
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WB;
        ST_WB: begin
          done  <= wb_ok;
          err   <= !wb_ok;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chip8_alu_issue.sv
// tb/tb_chip8_alu_issue.sv - self-checking bench for chip8_alu_issue driving the real ALU
module tb_chip8_alu_issue;
  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        done, err;
  logic [7:0]  alu_op1, alu_op2;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_out;
  logic        alu_carry, alu_err;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] mv [16];

  always #50 clk = ~clk;

  chip8_alu_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .done(done), .err(err), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_opcode(alu_opcode), .alu_out(alu_out), .alu_carry(alu_carry), .alu_err(alu_err),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready)
  );

  chip8_alu u_alu (
    .clk(clk), .rst(rst), .op1(alu_op1), .op2(alu_op2), .opcode(alu_opcode),
    .result(alu_out), .carry(alu_carry), .err(alu_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    chk($sformatf("reg_V%0h", a), {8'h0, rd_data}, {8'h0, exp});
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = i[3:0];
      #1;
      chk($sformatf("%s_V%0h", tag, i), {8'h0, rd_data}, {8'h0, mv[i]});
    end
  endtask

  task automatic ext_write(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    mv[a] = d;
  endtask

  // Reference behaviour of one 8XYN from the instruction-set rules, operands a=Vx, b=Vy.
  task automatic model_exec(input logic [15:0] ins, input int a, input int b, output bit rej);
    int hi, x, y, n, r, c;
    bit wvy, wvf;
    hi = int'(ins[15:12]); x = int'(ins[11:8]); y = int'(ins[7:4]); n = int'(ins[3:0]);
    r = 0; c = 0; wvy = 0; wvf = 1; rej = 0;
    case (n)
      0: begin r = b;      wvf = 0; end
      1: begin r = a | b;  wvf = 0; end
      2: begin r = a & b;  wvf = 0; end
      3: begin r = a ^ b;  wvf = 0; end
      4: begin r = a + b;  c = (a + b > 255) ? 1 : 0; end
      5: begin r = a - b;  c = (a >= b) ? 1 : 0; end
      6: begin r = b / 2;  c = b % 2; wvy = 1; end
      7: begin r = b - a;  c = (b >= a) ? 1 : 0; end
      14: begin r = b * 2; c = b / 128; wvy = 1; end
      default: rej = 1;
    endcase
    if (hi != 8) rej = 1;
    if (!rej) begin
      mv[x] = 8'(r & 255);
      if (wvy) mv[y] = 8'(r & 255);
      if (wvf) mv[15] = 8'(c);
    end
  endtask

  // mode 0: plain, 1: external write attempted in WB, 2: external write in ISSUE
  task automatic run(input logic [15:0] ins, input int mode);
    int a, b, cyc;
    bit rej;
    logic [3:0] pa;
    logic [7:0] pd;
    a = int'(mv[ins[11:8]]);
    b = int'(mv[ins[7:4]]);
    pa = 4'($urandom_range(0, 15));
    pd = 8'($urandom_range(0, 255));
    chk("instr_ready_idle", {15'h0, instr_ready}, 16'h1);
    instr_valid = 1'b1;
    instr = ins;
    step();
    instr_valid = 1'b0;
    instr = 16'h0;
    cyc = 1;
    chk("issue_op1", {8'h0, alu_op1}, 16'(a));
    chk("issue_op2", {8'h0, alu_op2}, 16'(b));
    chk("issue_opcode", {12'h0, alu_opcode}, {12'h0, ins[3:0]});
    chk("busy_ready", {15'h0, instr_ready}, 16'h0);
    while (!(done || err) && cyc < 8) begin
      if (mode == 2 && cyc == 1) begin
        wr_en = 1'b1; wr_addr = pa; wr_data = pd;
      end
      if (mode == 1 && cyc == 2) begin
        wr_en = 1'b1; wr_addr = pa; wr_data = pd;
        chk("wr_ready_wb", {15'h0, wr_ready}, 16'h0);
      end
      step();
      if (mode == 2 && cyc == 1) mv[pa] = pd;
      wr_en = 1'b0;
      cyc++;
    end
    chk("latency", 16'(cyc), 16'd3);
    model_exec(ins, a, b, rej);
    chk("done", {15'h0, done}, {15'h0, !rej});
    chk("err", {15'h0, err}, {15'h0, rej});
    check_all_regs("wb");
    step();
    chk("pulse_done", {15'h0, done}, 16'h0);
    chk("pulse_err", {15'h0, err}, 16'h0);
  endtask

  initial begin
    logic [3:0] legal [9];
    logic [3:0] hi, nn;
    legal = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE};
    rst = 1'b1; instr_valid = 1'b0; instr = '0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 16; i++) mv[i] = 8'h0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", {15'h0, instr_ready}, 16'h1);
    chk("rst_done", {15'h0, done}, 16'h0);
    chk("rst_err", {15'h0, err}, 16'h0);
    chk("rst_op1", {8'h0, alu_op1}, 16'h0);
    chk("rst_op2", {8'h0, alu_op2}, 16'h0);
    chk("rst_opcode", {12'h0, alu_opcode}, 16'h0);
    chk("rst_wr_ready", {15'h0, wr_ready}, 16'h1);
    check_all_regs("rst");

    // ADD with overflow
    ext_write(4'h1, 8'hF0); ext_write(4'h2, 8'h20);
    run(16'h8124, 0);
    check_reg(4'h1, 8'h10); check_reg(4'hF, 8'h01);

    // SUB with and without borrow
    ext_write(4'h3, 8'h10); ext_write(4'h4, 8'h20);
    run(16'h8345, 0);
    check_reg(4'h3, 8'hF0); check_reg(4'hF, 8'h00);
    ext_write(4'h3, 8'h30);
    run(16'h8345, 0);
    check_reg(4'h3, 8'h10); check_reg(4'hF, 8'h01);

    // Shifts write Vx and Vy
    ext_write(4'h5, 8'h81);
    run(16'h8656, 0);
    check_reg(4'h6, 8'h40); check_reg(4'h5, 8'h40); check_reg(4'hF, 8'h01);
    ext_write(4'h5, 8'h81);
    run(16'h865E, 0);
    check_reg(4'h6, 8'h02); check_reg(4'h5, 8'h02); check_reg(4'hF, 8'h01);

    // VF as destination: the flag write wins; rejected instructions change nothing
    ext_write(4'hF, 8'h05); ext_write(4'h1, 8'h0A);
    run(16'h8F14, 0);
    check_reg(4'hF, 8'h00);
    run(16'h8128, 0);
    run(16'h6123, 0);

    // External write during WB is dropped; in IDLE it shows up next cycle
    run(16'h8120, 1);
    rd_addr = 4'h7;
    wr_en = 1'b1; wr_addr = 4'h7; wr_data = 8'h33;
    #1;
    chk("rd_before_write", {8'h0, rd_data}, {8'h0, mv[7]});
    step();
    wr_en = 1'b0;
    mv[7] = 8'h33;
    chk("rd_after_write", {8'h0, rd_data}, 16'h33);

    // External write during ISSUE: operands already sampled stay the old values
    run(16'h8124, 2);

    // Reset while in ISSUE abandons the instruction
    ext_write(4'h9, 8'h77);
    instr_valid = 1'b1; instr = 16'h8994;
    step();
    instr_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mv[i] = 8'h0;
    chk("rst_mid_ready", {15'h0, instr_ready}, 16'h1);
    chk("rst_mid_done", {15'h0, done}, 16'h0);
    chk("rst_mid_err", {15'h0, err}, 16'h0);
    step();
    chk("rst_mid_done2", {15'h0, done}, 16'h0);
    chk("rst_mid_err2", {15'h0, err}, 16'h0);
    check_all_regs("rst_mid");

    // Randomised instructions against the reference model
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0)
        ext_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      hi = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h8;
      nn = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                       : legal[$urandom_range(0, 8)];
      run({hi, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), nn},
          int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
